// File: rtl/hood_mode_sequencer.sv
// hood_mode_sequencer
// Mode sequencer for the range hood, clocked from the 100 Hz tick domain.
// It takes one-hot mode requests and times the boost phase, the run-on after
// cancel and the self-clean. It also accumulates fan run time for the
// cleaning reminder.
//
// Ports:
//   clk_100Hz     in   100 Hz system tick clock
//   reset         in   asynchronous, active-high
//   power_on      in   level; low forces OFF
//   req_valid     in   request strobe, only honoured while req_ready=1
//   req_mode      in   one-hot request: 0001 lvl1, 0010 lvl2, 0100 lvl3, 1000 clean
//   cancel        in   pulse; running levels drop to the run-on phase
//   remind_clr    in   pulse; clears usage_sec and remind
//   req_ready     out  requests are accepted this cycle
//   reject        out  one-cycle pulse after an illegal accepted request
//   mode_out      out  one-hot mode drive for the fan/display datapath
//   state_code    out  0 OFF .. 6 CLEAN
//   countdown_sec out  seconds left in LVL3/EXIT/CLEAN, else 0
//   usage_sec     out  accumulated fan seconds, saturating
//   remind        out  usage_sec >= REMIND_SECONDS
module hood_mode_sequencer #(
  parameter int unsigned TICKS_PER_SEC  = 100,
  parameter int unsigned LVL3_SECONDS   = 60,
  parameter int unsigned EXIT_SECONDS   = 60,
  parameter int unsigned CLEAN_SECONDS  = 180,
  parameter int unsigned REMIND_SECONDS = 36000
) (
  input  logic        clk_100Hz,
  input  logic        reset,
  input  logic        power_on,
  input  logic        req_valid,
  input  logic [3:0]  req_mode,
  input  logic        cancel,
  input  logic        remind_clr,
  output logic        req_ready,
  output logic        reject,
  output logic [3:0]  mode_out,
  output logic [2:0]  state_code,
  output logic [7:0]  countdown_sec,
  output logic [15:0] usage_sec,
  output logic        remind
);

  localparam int unsigned PreW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PreW-1:0] PreMax    = PreW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]      Lvl3Secs  = 8'(LVL3_SECONDS);
  localparam logic [7:0]      ExitSecs  = 8'(EXIT_SECONDS);
  localparam logic [7:0]      CleanSecs = 8'(CLEAN_SECONDS);
  localparam logic [15:0]     RemindThr = 16'(REMIND_SECONDS);

  // Encoding doubles as the state_code output.
  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StStandby = 3'd1,
    StLvl1    = 3'd2,
    StLvl2    = 3'd3,
    StLvl3    = 3'd4,
    StExit    = 3'd5,
    StClean   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cd_q, cd_d;
  logic [PreW-1:0] phase_pre_q, phase_pre_d;
  logic [PreW-1:0] use_pre_q, use_pre_d;
  logic            lvl3_used_q, lvl3_used_d;
  logic            reject_q, reject_d;
  logic            ready_q, ready_d;
  logic [3:0]      mode_q, mode_d;
  logic [15:0]     usage_q, usage_d;
  logic            remind_q, remind_d;

  logic timed, running, phase_wrap, expire, use_wrap, accept, clean_done;

  assign timed      = state_q inside {StLvl3, StExit, StClean};
  assign running    = state_q inside {StLvl1, StLvl2, StLvl3, StExit};
  assign phase_wrap = timed && (phase_pre_q == PreMax);
  assign expire     = phase_wrap && (cd_q == 8'd1);
  assign use_wrap   = running && (use_pre_q == PreMax);
  assign accept     = req_valid && ready_q;

  // State register
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      state_q     <= StOff;
      cd_q        <= '0;
      phase_pre_q <= '0;
      use_pre_q   <= '0;
      lvl3_used_q <= 1'b0;
      reject_q    <= 1'b0;
      ready_q     <= 1'b0;
      mode_q      <= 4'b0000;
      usage_q     <= '0;
      remind_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      phase_pre_q <= phase_pre_d;
      use_pre_q   <= use_pre_d;
      lvl3_used_q <= lvl3_used_d;
      reject_q    <= reject_d;
      ready_q     <= ready_d;
      mode_q      <= mode_d;
      usage_q     <= usage_d;
      remind_q    <= remind_d;
    end
  end

  // Next-state: events resolved in priority order power-off, cancel, expiry, request.
  always_comb begin
    state_d     = state_q;
    cd_d        = cd_q;
    phase_pre_d = phase_pre_q;
    lvl3_used_d = lvl3_used_q;
    reject_d    = 1'b0;
    clean_done  = 1'b0;

    if (timed) begin
      phase_pre_d = phase_wrap ? '0 : phase_pre_q + PreW'(1);
      if (phase_wrap) cd_d = cd_q - 8'd1;
    end

    if (!power_on) begin
      state_d     = StOff;
      cd_d        = '0;
      phase_pre_d = '0;
      lvl3_used_d = 1'b0;
    end else if (state_q == StOff) begin
      state_d = StStandby;
    end else if (cancel && (state_q inside {StLvl1, StLvl2, StLvl3})) begin
      state_d     = StExit;
      cd_d        = ExitSecs;
      phase_pre_d = '0;
    end else if (expire) begin
      // cd_d has already reached zero via the wrap decrement above.
      unique case (state_q)
        StLvl3:  state_d = StLvl2;
        StExit:  state_d = StStandby;
        StClean: begin
          state_d    = StStandby;
          clean_done = 1'b1;
        end
        default: ;
      endcase
    end else if (accept) begin
      if (!$onehot(req_mode)) begin
        reject_d = 1'b1;
      end else if (req_mode[2]) begin
        if (lvl3_used_q) begin
          reject_d = 1'b1;
        end else begin
          state_d     = StLvl3;
          cd_d        = Lvl3Secs;
          phase_pre_d = '0;
          lvl3_used_d = 1'b1;
        end
      end else if (req_mode[3]) begin
        if (state_q == StStandby) begin
          state_d     = StClean;
          cd_d        = CleanSecs;
          phase_pre_d = '0;
        end else begin
          reject_d = 1'b1;
        end
      end else if (req_mode[0]) begin
        state_d = StLvl1;
      end else begin
        state_d = StLvl2;
      end
    end
  end

  // Usage accounting: prescaler only advances while the fan runs.
  always_comb begin
    use_pre_d = use_pre_q;
    usage_d   = usage_q;
    if (running) use_pre_d = use_wrap ? '0 : use_pre_q + PreW'(1);
    if (use_wrap && (usage_q != 16'hFFFF)) usage_d = usage_q + 16'd1;
    if (clean_done || remind_clr) usage_d = '0;
    remind_d = (usage_d >= RemindThr);
  end

  // Output decode, registered alongside the state.
  always_comb begin
    ready_d = state_d inside {StStandby, StLvl1, StLvl2};
    mode_d  = 4'b0000;
    unique case (state_d)
      StOff:     mode_d = 4'b0000;
      StStandby: mode_d = 4'b1111;
      StLvl1:    mode_d = 4'b0001;
      StLvl2:    mode_d = 4'b0010;
      StLvl3:    mode_d = 4'b0100;
      StExit:    mode_d = 4'b0001;
      StClean:   mode_d = 4'b1000;
      default:   mode_d = 4'b0000;
    endcase
  end

  assign req_ready     = ready_q;
  assign reject        = reject_q;
  assign mode_out      = mode_q;
  assign state_code    = state_q;
  assign countdown_sec = cd_q;
  assign usage_sec     = usage_q;
  assign remind        = remind_q;

endmodule

// File: tb/tb_hood_mode_sequencer.sv
// Scoreboard bench for hood_mode_sequencer: directed scenarios followed by random
// stimulus, checked against a cycle-count reference model.
module tb_hood_mode_sequencer;

  localparam int T  = 2;
  localparam int L3 = 3;
  localparam int EX = 2;
  localparam int CL = 4;
  localparam int RM = 5;

  logic        clk_100Hz = 1'b0;
  logic        reset;
  logic        power_on;
  logic        req_valid;
  logic [3:0]  req_mode;
  logic        cancel;
  logic        remind_clr;
  logic        req_ready;
  logic        reject;
  logic [3:0]  mode_out;
  logic [2:0]  state_code;
  logic [7:0]  countdown_sec;
  logic [15:0] usage_sec;
  logic        remind;

  hood_mode_sequencer #(
    .TICKS_PER_SEC (T),
    .LVL3_SECONDS  (L3),
    .EXIT_SECONDS  (EX),
    .CLEAN_SECONDS (CL),
    .REMIND_SECONDS(RM)
  ) dut (
    .clk_100Hz    (clk_100Hz),
    .reset        (reset),
    .power_on     (power_on),
    .req_valid    (req_valid),
    .req_mode     (req_mode),
    .cancel       (cancel),
    .remind_clr   (remind_clr),
    .req_ready    (req_ready),
    .reject       (reject),
    .mode_out     (mode_out),
    .state_code   (state_code),
    .countdown_sec(countdown_sec),
    .usage_sec    (usage_sec),
    .remind       (remind)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  typedef struct {
    int code;
    int mode;
    int ready;
    int rej;
    int cd;
    int usage;
    int rem;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: state by spec code, timed phases as remaining clock cycles,
  // usage as total running cycles minus a mark taken at each clear.
  int m_state;
  int m_rem;
  bit m_l3used;
  int m_ticks;
  int m_mark;
  bit m_rej;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic int mode_of(input int s);
    case (s)
      1:       return 15;
      2:       return 1;
      3:       return 2;
      4:       return 4;
      5:       return 1;
      6:       return 8;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_l3used = 0; m_ticks = 0; m_mark = 0; m_rej = 0;
  endtask

  task automatic model_step(input bit pw, input bit rv, input logic [3:0] rm, input bit cn,
                            input bit rc);
    int   s = m_state;
    bit   tmd = (s >= 4);
    int   u;
    exp_t e;
    m_rej = 0;
    if (s >= 2 && s <= 5) m_ticks++;
    if (!pw) begin
      m_state = 0; m_l3used = 0; m_rem = 0;
    end else if (s == 0) begin
      m_state = 1;
    end else if (cn && s >= 2 && s <= 4) begin
      m_state = 5; m_rem = EX * T;
    end else if (tmd && m_rem == 1) begin
      m_rem = 0;
      m_state = (s == 4) ? 3 : 1;
      if (s == 6) m_mark = m_ticks / T;
    end else if (rv && s >= 1 && s <= 3) begin
      if ($countones(rm) != 1) m_rej = 1;
      else if (rm == 4'b0100) begin
        if (m_l3used) m_rej = 1;
        else begin m_state = 4; m_rem = L3 * T; m_l3used = 1; end
      end else if (rm == 4'b1000) begin
        if (s == 1) begin m_state = 6; m_rem = CL * T; end
        else m_rej = 1;
      end else m_state = (rm == 4'b0001) ? 2 : 3;
    end else if (tmd) begin
      m_rem--;
    end
    if (rc) m_mark = m_ticks / T;
    u = m_ticks / T - m_mark;
    if (u > 65535) u = 65535;
    e.code  = m_state;
    e.mode  = mode_of(m_state);
    e.ready = (m_state >= 1 && m_state <= 3) ? 1 : 0;
    e.rej   = m_rej;
    e.cd    = (m_state >= 4) ? (m_rem + T - 1) / T : 0;
    e.usage = u;
    e.rem   = (u >= RM) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: every settled cycle presents a full output word.
  always @(negedge clk_100Hz) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state_code", int'(state_code), e.code);
      chk("mode_out", int'(mode_out), e.mode);
      chk("req_ready", int'(req_ready), e.ready);
      chk("reject", int'(reject), e.rej);
      chk("countdown_sec", int'(countdown_sec), e.cd);
      chk("usage_sec", int'(usage_sec), e.usage);
      chk("remind", int'(remind), e.rem);
    end
  end

  task automatic cycle(input bit pw, input bit rv, input logic [3:0] rm, input bit cn,
                       input bit rc);
    @(negedge clk_100Hz);
    power_on = pw; req_valid = rv; req_mode = rm; cancel = cn; remind_clr = rc;
    @(posedge clk_100Hz);
    #1;
    model_step(pw, rv, rm, cn, rc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 4'b0000, 0, 0);
  endtask

  task automatic req(input logic [3:0] rm);
    cycle(1, 1, rm, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".mode_out"}, int'(mode_out), 0);
    chk({tag, ".state_code"}, int'(state_code), 0);
    chk({tag, ".req_ready"}, int'(req_ready), 0);
    chk({tag, ".reject"}, int'(reject), 0);
    chk({tag, ".countdown_sec"}, int'(countdown_sec), 0);
    chk({tag, ".usage_sec"}, int'(usage_sec), 0);
    chk({tag, ".remind"}, int'(remind), 0);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic mid_cycle_reset(input string tag);
    @(negedge clk_100Hz);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    model_reset();
    @(negedge clk_100Hz);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; power_on = 1'b0; req_valid = 1'b0; req_mode = 4'b0000;
    cancel = 1'b0; remind_clr = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk_100Hz);
    #2;
    reset = 1'b0;

    // Power up, lvl2, then boost and auto-return; second boost rejected.
    idle(1);
    req(4'b0010);
    idle(2);
    req(4'b0100);
    idle(8);
    req(4'b0100);
    idle(2);
    // Level 1, cancel into run-on, back to standby.
    req(4'b0001);
    idle(3);
    cycle(1, 0, 4'b0000, 1, 0);
    idle(6);
    // Run long enough to raise the reminder, then clean with an ignored cancel.
    req(4'b0001);
    idle(10);
    cycle(1, 0, 4'b0000, 1, 0);
    idle(5);
    req(4'b1000);
    idle(2);
    cycle(1, 0, 4'b0000, 1, 0);
    idle(8);
    // Clean from a level is illegal; same-mode is a no-op; cancel beats request.
    req(4'b0010);
    req(4'b1000);
    req(4'b0010);
    cycle(1, 1, 4'b0001, 1, 0);
    idle(6);
    // Power off mid-clean, power back on, boost allowed again.
    req(4'b1000);
    idle(3);
    cycle(0, 0, 4'b0000, 0, 0);
    cycle(0, 1, 4'b0001, 0, 0);
    idle(2);
    req(4'b0100);
    idle(2);
    mid_cycle_reset("reset_lvl3");
    // Non-one-hot requests in standby.
    idle(2);
    req(4'b0110);
    idle(1);
    req(4'b0000);
    idle(1);
    cycle(1, 0, 4'b0000, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      bit          pw, rv, cn, rc;
      logic [3:0]  rm;
      pw = ($urandom_range(0, 99) != 0);
      rv = ($urandom_range(0, 2) == 0);
      rm = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cn = ($urandom_range(0, 11) == 0);
      rc = ($urandom_range(0, 39) == 0);
      cycle(pw, rv, rm, cn, rc);
      if (i == 1500) mid_cycle_reset("reset_random");
    end

    @(negedge clk_100Hz);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
